// File: rtl/exec_cond_pkg.sv
// Shared types and constants for the execute-stage condition unit.
package exec_cond_pkg;

  // ARM-style condition codes
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Bit positions inside an NZCV nibble
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flags_t;

endpackage

// File: rtl/exec_cond_if.sv
// Execute-stage bundle: ungated E-stage controls/data in, gated M-stage
// register plus combinational flush/flag feedback out.
// There is no valid/ready handshake: every signal is meaningful on every
// cycle; a flushed or bubble slot is simply all-zero controls.
interface exec_cond_if #(
  parameter int WIDTH = 32
);
  import exec_cond_pkg::*;

  logic [3:0]       CondE;
  flags_t           FlagsE;
  logic [1:0]       FlagWriteE;
  flags_t           ALUFlagsE;
  logic             PCSrcE;
  logic             RegWriteE;
  logic             MemWriteE;
  logic             MemtoRegE;
  logic             BranchE;
  logic [3:0]       WA3E;
  logic [WIDTH-1:0] ALUResultE;
  logic [WIDTH-1:0] WriteDataE;

  flags_t           FlagsD;
  logic             FlushE;
  logic             FlushD;
  logic             CondExE;
  logic             PCSrcM;
  logic             RegWriteM;
  logic             MemWriteM;
  logic             MemtoRegM;
  logic [3:0]       WA3M;
  logic [WIDTH-1:0] ALUResultM;
  logic [WIDTH-1:0] WriteDataM;

  // Pipeline side that feeds the execute stage
  modport master (
    output CondE, FlagsE, FlagWriteE, ALUFlagsE, PCSrcE, RegWriteE,
           MemWriteE, MemtoRegE, BranchE, WA3E, ALUResultE, WriteDataE,
    input  FlagsD, FlushE, FlushD, CondExE, PCSrcM, RegWriteM,
           MemWriteM, MemtoRegM, WA3M, ALUResultM, WriteDataM
  );

  // The condition unit itself
  modport slave (
    input  CondE, FlagsE, FlagWriteE, ALUFlagsE, PCSrcE, RegWriteE,
           MemWriteE, MemtoRegE, BranchE, WA3E, ALUResultE, WriteDataE,
    output FlagsD, FlushE, FlushD, CondExE, PCSrcM, RegWriteM,
           MemWriteM, MemtoRegM, WA3M, ALUResultM, WriteDataM
  );
endinterface

// File: rtl/exec_cond_cond_check.sv
// Combinational condition evaluation of a 4-bit code against NZCV.
module cond_check
  import exec_cond_pkg::*;
(
  input  logic [3:0] cond,
  input  flags_t     flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Decode the condition code into a pass/fail decision
  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/exec_cond_unit.sv
// Execute-stage condition unit: evaluates the condition, owns the NZCV
// register, gates side-effecting controls into the execute->memory
// register and raises the branch flush.
module exec_cond_unit
  import exec_cond_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  exec_cond_if.slave  bus
);

  flags_t flags_q;
  flags_t flags_next;
  logic   cond_ex;
  logic   wr_nz;
  logic   wr_cv;

  cond_check u_cond_check (
    .cond  (bus.CondE),
    .flags (bus.FlagsE),
    .pass  (cond_ex)
  );

  // Flag writes are suppressed while reset is asserted so the bypass
  // never advertises a value the register will not take.
  assign wr_nz = reset & cond_ex & bus.FlagWriteE[1];
  assign wr_cv = reset & cond_ex & bus.FlagWriteE[0];

  // Next-state flags: N,Z and C,V halves update independently
  always_comb begin
    flags_next = flags_q;
    if (wr_nz) begin
      flags_next[FLAG_N] = bus.ALUFlagsE[FLAG_N];
      flags_next[FLAG_Z] = bus.ALUFlagsE[FLAG_Z];
    end
    if (wr_cv) begin
      flags_next[FLAG_C] = bus.ALUFlagsE[FLAG_C];
      flags_next[FLAG_V] = bus.ALUFlagsE[FLAG_V];
    end
  end

  // Architectural NZCV register
  always_ff @(posedge clk) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_next;
  end

  // Same-cycle bypass lets the decode instruction capture fresh flags
  assign bus.FlagsD  = flags_next;
  assign bus.CondExE = cond_ex;
  assign bus.FlushE  = (bus.BranchE | bus.PCSrcE) & cond_ex;
  assign bus.FlushD  = (bus.BranchE | bus.PCSrcE) & cond_ex;

  // Execute->memory register; data loads even when the condition fails
  always_ff @(posedge clk) begin
    if (!reset) begin
      bus.PCSrcM     <= 1'b0;
      bus.RegWriteM  <= 1'b0;
      bus.MemWriteM  <= 1'b0;
      bus.MemtoRegM  <= 1'b0;
      bus.WA3M       <= '0;
      bus.ALUResultM <= '0;
      bus.WriteDataM <= '0;
    end else begin
      bus.PCSrcM     <= bus.PCSrcE & cond_ex;
      bus.RegWriteM  <= bus.RegWriteE & cond_ex;
      bus.MemWriteM  <= bus.MemWriteE & cond_ex;
      bus.MemtoRegM  <= bus.MemtoRegE;
      bus.WA3M       <= bus.WA3E;
      bus.ALUResultM <= bus.ALUResultE;
      bus.WriteDataM <= bus.WriteDataE;
    end
  end

endmodule

// File: doc/exec_cond_unit.md
Name: exec_cond_unit

Overview:
- Execute-stage consumer of the decode→execute pipeline register outputs (CondE, FlagsE, FlagWriteE, PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE, WA3E).
- Evaluates the instruction condition against the flags carried into execute, owns the architectural NZCV register, and gates control signals into the execute→memory register it contains.
- Returns the flush back to the decode→execute register clear input and forwards next-state flags to decode.

Parameters:
- WIDTH, 32, datapath width of ALU result and store data carried to memory stage.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-low; 0 = reset, sampled on rising clk.
- CondE  in  4  condition code of execute-stage instruction.
- FlagsE  in  4  NZCV seen by the execute instruction (N=3, Z=2, C=1, V=0).
- FlagWriteE  in  2  bit1 = write N,Z; bit0 = write C,V.
- ALUFlagsE  in  4  NZCV produced by ALU this cycle.
- PCSrcE, RegWriteE, MemWriteE, MemtoRegE, BranchE  in  1 each  ungated execute controls.
- WA3E  in  4  destination register.
- ALUResultE, WriteDataE  in  WIDTH each  execute results.
- FlagsD  out  4  flags for decode (feeds decode→execute register flags input), bypassed.
- FlushE  out  1  clear for decode→execute register (combinational).
- FlushD  out  1  clear for fetch→decode register (combinational).
- CondExE  out  1  condition passed (combinational, debug/visibility).
- PCSrcM, RegWriteM, MemWriteM, MemtoRegM  out  1 each  gated registered controls.
- WA3M  out  4  registered destination.
- ALUResultM, WriteDataM  out  WIDTH each  registered data.

Behaviour:
- Reset (reset=0 at rising clk): flag register = 4'b0000; all *M outputs = 0. Combinational outputs follow the reset register values (FlagsD = 0000 unless a write is in flight; write enables are forced 0 during reset).
- Condition, from FlagsE: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 never (0).
- Gating: each of PCSrc/RegWrite/MemWrite = ungated & CondExE. MemtoReg passes ungated.
- Flag register update at rising clk when CondExE: FlagWriteE[1] loads N,Z from ALUFlagsE[3:2]; FlagWriteE[0] loads C,V from ALUFlagsE[1:0]. Halves are independent. Failed condition means no update.
- FlagsD = next-state flag value (same-cycle bypass), so the decode instruction behind a flag-setter captures the new flags; no stall is needed.
- Branch: BranchTakenE = (BranchE | PCSrcE) & CondExE. FlushE = FlushD = BranchTakenE, same cycle. A flushed slot arrives next cycle with all controls 0 (cleared by the upstream register) and produces no writes.
- Memory-stage register latency: 1 cycle. Every *M output equals its gated E value from the previous cycle. It updates every cycle (no stall input). Data fields load even when the condition fails.
- Simultaneous events: a taken branch that also sets flags updates the flags and flushes in the same cycle.
- Reset mid-operation: reset wins over every update. The following cycle shows zeros.

Decomposition:
- Package exec_cond_pkg:
  - cond_e enum (EQ..NV, 4-bit).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef flags_t (logic[3:0]).
- Sub-module cond_check: combinational (cond, flags) → pass. This is the sole sub-module. The flag register and memory-stage register stay in the top.

Test Plan:
- Reset held 2 cycles, then released → FlagsD=0000, all *M=0, FlushE=0.
- CondE=1110, FlagWriteE=11, ALUFlagsE=0100, RegWriteE=1, WA3E=5, ALUResultE=32'h0 → same cycle FlagsD=0100. Next cycle RegWriteM=1, WA3M=5; the flag register holds 0100.
- FlagsE=0100, CondE=0001 (NE), MemWriteE=1, FlagWriteE=11, ALUFlagsE=1000 → CondExE=0, MemWriteM=0 next cycle, flags unchanged at 0100.
- FlagsE=0100, CondE=0000, BranchE=1 → FlushE=FlushD=1 same cycle; repeat with CondE=0001 → both 0.
- Flags=1111, FlagWriteE=10, ALUFlagsE=0000, CondE=1110 → flags become 0011 (C,V retained).
- CondE=1111, RegWriteE=1, PCSrcE=1 → CondExE=0, FlushE=0, RegWriteM=0, PCSrcM=0. Assert reset with valid E inputs → next cycle all *M=0 and flags=0000.
